// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone arbiter with a held grant and a hung-cycle watchdog.
// Define WB_ARB_RR_EN for a round-robin tie-break; without it m0 always wins ties.
module wb_arbiter_2m #(
   parameter int          TIMEOUT = 255,
   parameter logic [31:0] TO_DATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_data_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_stb_i,
   input  logic        m0_cyc_i,
   output logic [31:0] m0_data_o,
   output logic        m0_ack_o,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_data_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_stb_i,
   input  logic        m1_cyc_i,
   output logic [31:0] m1_data_o,
   output logic        m1_ack_o,
   output logic [31:0] s_addr_o,
   output logic [31:0] s_data_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   input  logic [31:0] s_data_i,
   input  logic        s_ack_i,
   output logic [1:0]  grant_o,
   output logic        timeout_o
);
   typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        to_q, tie_m0, g0, g1, g_stb, g_cyc, to;
   logic [31:0] rsp;
`ifdef WB_ARB_RR_EN
   state_t last_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) last_q <= G1;
      else if (state_d != IDLE) last_q <= state_d;
   assign tie_m0 = (last_q == G1);
`else
   assign tie_m0 = 1'b1;
`endif
   always_comb begin
      state_d = state_q;
      case (state_q)
         G0:      state_d = m0_cyc_i ? G0 : m1_cyc_i ? G1 : IDLE;
         G1:      state_d = m1_cyc_i ? G1 : m0_cyc_i ? G0 : IDLE;
         default: state_d = (m0_cyc_i && (!m1_cyc_i || tie_m0)) ? G0 : m1_cyc_i ? G1 : IDLE;
      endcase
   end
   assign g0    = (state_q == G0);
   assign g1    = (state_q == G1);
   assign g_stb = (g0 & m0_stb_i) | (g1 & m1_stb_i);
   assign g_cyc = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
   // A forced completion masks the slave strobe so the hung slave sees the cycle end.
   assign to    = g_stb && (cnt_q == 16'(TIMEOUT));
   assign cnt_d = (state_d != state_q || s_ack_i || !g_stb || to) ? 16'd0 : cnt_q + 16'd1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 16'd0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         to_q    <= to;
      end
   assign s_addr_o  = g0 ? m0_addr_i : g1 ? m1_addr_i : 32'd0;
   assign s_data_o  = g0 ? m0_data_i : g1 ? m1_data_i : 32'd0;
   assign s_we_o    = g0 ? m0_we_i : g1 & m1_we_i;
   assign s_sel_o   = g0 ? m0_sel_i : g1 ? m1_sel_i : 4'd0;
   assign s_stb_o   = g_stb & ~to;
   assign s_cyc_o   = g_cyc & ~to;
   assign rsp       = to ? TO_DATA : s_data_i;
   assign m0_ack_o  = g0 & (s_ack_i | to);
   assign m1_ack_o  = g1 & (s_ack_i | to);
   assign m0_data_o = g0 ? rsp : 32'd0;
   assign m1_data_o = g1 ? rsp : 32'd0;
   assign grant_o   = state_q;
   assign timeout_o = to_q;
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: vector-table bench for wb_arbiter_2m built with TIMEOUT=4.
module tb_wb_arbiter_2m;
   localparam logic [31:0] TOD = 32'hDEAD_BEEF;
   localparam logic [31:0] A0 = 32'h0000_0100, A1 = 32'h0000_0040, WD = 32'hAABB_CCDD;
   logic clk = 1'b0, rst = 1'b1;
   logic [31:0] m0_addr_i = A0, m0_data_i = WD, m1_addr_i = A1, m1_data_i = 32'd0, s_data_i = 32'd0;
   logic m0_we_i = 1'b1, m1_we_i = 1'b0, m0_stb_i = 1'b0, m0_cyc_i = 1'b0, m1_stb_i = 1'b0, m1_cyc_i = 1'b0, s_ack_i = 1'b0;
   logic [3:0] m0_sel_i = 4'b0011, m1_sel_i = 4'hF;
   logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
   logic m0_ack_o, m1_ack_o, s_we_o, s_stb_o, s_cyc_o, timeout_o;
   logic [3:0] s_sel_o;
   logic [1:0] grant_o;
   int tests = 0, fails = 0;

   typedef struct packed {
      logic c0, s0, c1, s1, ack;
      logic [31:0] sd;
   } in_t;
   typedef struct packed {
      logic [1:0] g;
      logic scyc, sstb;
      logic [31:0] saddr, sdat;
      logic [3:0] ssel;
      logic a0;
      logic [31:0] d0;
      logic a1;
      logic [31:0] d1;
      logic to;
   } out_t;
   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;
   vec_t vq[$];

   wb_arbiter_2m #(.TIMEOUT(4), .TO_DATA(TOD)) dut (
      .clk(clk), .rst(rst),
      .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
      .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
      .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   function automatic out_t actual();
      return '{grant_o, s_cyc_o, s_stb_o, s_addr_o, s_data_o, s_sel_o, m0_ack_o, m0_data_o, m1_ack_o, m1_data_o, timeout_o};
   endfunction

   // Expected slave-side view for each grant: idle, m0 (write), m1 (read).
   task automatic add(input logic [4:0] ins, input logic [31:0] sd, input logic [1:0] g,
                      input logic scyc, input logic sstb, input logic a0, input logic [31:0] d0,
                      input logic a1, input logic [31:0] d1, input logic to);
      vec_t v;
      v.i = '{ins[4], ins[3], ins[2], ins[1], ins[0], sd};
      v.o = '{g, scyc, sstb, g == 2'b01 ? A0 : g == 2'b10 ? A1 : 32'd0, g == 2'b01 ? WD : 32'd0,
              g == 2'b01 ? 4'b0011 : g == 2'b10 ? 4'hF : 4'h0, a0, d0, a1, d1, to};
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [138:0] act, input logic [138:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      logic [1:0] gt;
`ifdef WB_ARB_RR_EN
      gt = 2'b10;
`else
      gt = 2'b01;
`endif
      // ins = {c0, s0, c1, s1, ack}
      add(5'b00001, 32'h55, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      add(5'b00110, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) add(5'b00110, 0, 2'b10, 1, 1, 0, 0, 0, 0, 0);
      add(5'b00111, 32'h1234_5678, 2'b10, 1, 1, 0, 0, 1, 32'h1234_5678, 0);
      add(5'b00000, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
      add(5'b11110, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      add(5'b11110, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
      add(5'b00000, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
      add(5'b11110, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      add(5'b11110, 0, gt, 1, 1, 0, 0, 0, 0, 0);
      add(5'b00000, 0, gt, 0, 0, 0, 0, 0, 0, 0);
      add(5'b11110, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      add(5'b11111, 0, 2'b01, 1, 1, 1, 0, 0, 0, 0);
      add(5'b00110, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
      add(5'b00110, 0, 2'b10, 1, 1, 0, 0, 0, 0, 0);
      add(5'b00000, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
      add(5'b11000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) add(5'b11000, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
      add(5'b11000, 32'hFFFF_FFFF, 2'b01, 0, 0, 1, TOD, 0, 0, 0);
      add(5'b11000, 0, 2'b01, 1, 1, 0, 0, 0, 0, 1);
      add(5'b00000, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
      add(5'b00000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

      #3;
      chk("reset_state", actual(), '0);
      @(negedge clk) rst = 1'b0;
      foreach (vq[k]) begin
         {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i} = {vq[k].i.c0, vq[k].i.s0, vq[k].i.c1, vq[k].i.s1, vq[k].i.ack};
         s_data_i = vq[k].i.sd;
         #1;
         chk($sformatf("vec%0d", k), actual(), vq[k].o);
         @(negedge clk);
      end

      // Asynchronous reset in the middle of an m1 transfer, m0 waiting.
      {m1_cyc_i, m1_stb_i} = 2'b11;
      @(negedge clk) {m0_cyc_i, m0_stb_i} = 2'b11;
      #1 chk("pre_rst_grant", {137'd0, grant_o}, {137'd0, 2'b10});
      #2 rst = 1'b1;
      #1 chk("async_rst", {136'd0, grant_o, s_cyc_o}, '0);
      @(negedge clk) begin
         rst = 1'b0;
         {m1_cyc_i, m1_stb_i} = 2'b00;
      end
      #1 chk("post_rst_idle", {137'd0, grant_o}, '0);
      @(posedge clk) #1 chk("post_rst_grant", {136'd0, grant_o, s_cyc_o}, {136'd0, 2'b01, 1'b1});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
